// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: merges a single-cycle ALU source (A) with a buffered
// load/multi-cycle source (B) into one registered register-file write per cycle.
module rf_wb_arbiter #(
  parameter int unsigned BW_DATA       = 32,
  parameter int unsigned BW_ADDR       = 5,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter bit          ZERO_REG_DROP = 1'b1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_a_valid,
  output logic                          o_a_ready,
  input  logic [BW_ADDR-1:0]            i_a_addr,
  input  logic [BW_DATA-1:0]            i_a_data,
  input  logic                          i_b_valid,
  output logic                          o_b_ready,
  input  logic [BW_ADDR-1:0]            i_b_addr,
  input  logic [BW_DATA-1:0]            i_b_data,
  output logic                          o_rf_wr_en,
  output logic [BW_ADDR-1:0]            o_rf_wr_addr,
  output logic [BW_DATA-1:0]            o_rf_wr_data,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [BW_ADDR-1:0] mem_addr_q [FIFO_DEPTH];
  logic [BW_DATA-1:0] mem_data_q [FIFO_DEPTH];

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [BW_ADDR-1:0] wr_addr_q, wr_addr_d;
  logic [BW_DATA-1:0] wr_data_q, wr_data_d;

  logic               full;
  logic               push;
  logic               pop;
  logic               grant_a;
  logic               issue;
  logic [BW_ADDR-1:0] gnt_addr;
  logic [BW_DATA-1:0] gnt_data;

  // Handshakes and arbitration: a full FIFO wins over A so B cannot starve
  always_comb begin
    full      = (cnt_q == CW'(FIFO_DEPTH));
    o_a_ready = !i_rst && !full;
    o_b_ready = !i_rst && !full;
    push      = i_b_valid && o_b_ready;
    grant_a   = i_a_valid && o_a_ready;
    pop       = !i_rst && (full || (!i_a_valid && (cnt_q != '0)));
    gnt_addr  = grant_a ? i_a_addr : mem_addr_q[rd_ptr_q];
    gnt_data  = grant_a ? i_a_data : mem_data_q[rd_ptr_q];
    issue     = (grant_a || pop) && !(ZERO_REG_DROP && (gnt_addr == '0));
  end

  // Next-state for FIFO pointers, occupancy and the write-port register
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    cnt_d     = cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    if (issue) begin
      wr_en_d   = 1'b1;
      wr_addr_d = gnt_addr;
      wr_data_d = gnt_data;
    end
  end

  // Control and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset
  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= i_b_addr;
      mem_data_q[wr_ptr_q] <= i_b_data;
    end
  end

  assign o_rf_wr_en   = wr_en_q;
  assign o_rf_wr_addr = wr_addr_q;
  assign o_rf_wr_data = wr_data_q;
  assign o_fifo_cnt   = cnt_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed scenarios plus randomized traffic checked
// against a queue-based model; two instances cover both zero-register modes.
module tb_rf_wb_arbiter;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        a_valid, b_valid;
  logic [4:0]  a_addr, b_addr;
  logic [31:0] a_data, b_data;

  logic        a_rdy0, b_rdy0, en0;
  logic [4:0]  addr0;
  logic [31:0] data0;
  logic [2:0]  cnt0;
  logic        a_rdy1, b_rdy1, en1;
  logic [4:0]  addr1;
  logic [31:0] data1;
  logic [2:0]  cnt1;

  rf_wb_arbiter #(.BW_DATA(32), .BW_ADDR(5), .FIFO_DEPTH(DEPTH), .ZERO_REG_DROP(1'b1)) u_drop (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .o_a_ready(a_rdy0), .i_a_addr(a_addr), .i_a_data(a_data),
    .i_b_valid(b_valid), .o_b_ready(b_rdy0), .i_b_addr(b_addr), .i_b_data(b_data),
    .o_rf_wr_en(en0), .o_rf_wr_addr(addr0), .o_rf_wr_data(data0), .o_fifo_cnt(cnt0)
  );

  rf_wb_arbiter #(.BW_DATA(32), .BW_ADDR(5), .FIFO_DEPTH(DEPTH), .ZERO_REG_DROP(1'b0)) u_keep (
    .i_clk(clk), .i_rst(rst),
    .i_a_valid(a_valid), .o_a_ready(a_rdy1), .i_a_addr(a_addr), .i_a_data(a_data),
    .i_b_valid(b_valid), .o_b_ready(b_rdy1), .i_b_addr(b_addr), .i_b_data(b_data),
    .o_rf_wr_en(en1), .o_rf_wr_addr(addr1), .o_rf_wr_data(data1), .o_fifo_cnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: B entries waiting, expected write port per instance
  logic [4:0]  mq_addr[$];
  logic [31:0] mq_data[$];
  logic        e_en [2];
  logic [4:0]  e_addr [2];
  logic [31:0] e_data [2];

  // One clock of stimulus: drive, check readies, advance model, check outputs
  task automatic cycle(input bit r, input bit av, input logic [4:0] aa, input logic [31:0] ad,
                       input bit bv, input logic [4:0] ba, input logic [31:0] bd);
    bit          is_full, ga, gb;
    logic [4:0]  g_addr;
    logic [31:0] g_data;
    @(negedge clk);
    rst = r; a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    #1;
    is_full = (mq_addr.size() == DEPTH);
    chk("a_ready", {a_rdy1, a_rdy0}, {2{!r && !is_full}});
    chk("b_ready", {b_rdy1, b_rdy0}, {2{!r && !is_full}});
    if (r) begin
      mq_addr.delete();
      mq_data.delete();
      for (int k = 0; k < 2; k++) begin
        e_en[k] = 1'b0; e_addr[k] = '0; e_data[k] = '0;
      end
    end else begin
      ga = 1'b0; gb = 1'b0; g_addr = '0; g_data = '0;
      if (is_full) gb = 1'b1;
      else if (av) ga = 1'b1;
      else if (mq_addr.size() > 0) gb = 1'b1;
      if (ga) begin
        g_addr = aa; g_data = ad;
      end
      if (gb) begin
        g_addr = mq_addr.pop_front();
        g_data = mq_data.pop_front();
      end
      if (bv && !is_full) begin
        mq_addr.push_back(ba);
        mq_data.push_back(bd);
      end
      for (int k = 0; k < 2; k++) begin
        if ((ga || gb) && !(k == 0 && g_addr == 5'd0)) begin
          e_en[k] = 1'b1; e_addr[k] = g_addr; e_data[k] = g_data;
        end else begin
          e_en[k] = 1'b0;
        end
      end
    end
    @(posedge clk);
    #1;
    chk("drop_wr_en",   en0,   e_en[0]);
    chk("drop_wr_addr", addr0, e_addr[0]);
    chk("drop_wr_data", data0, e_data[0]);
    chk("keep_wr_en",   en1,   e_en[1]);
    chk("keep_wr_addr", addr1, e_addr[1]);
    chk("keep_wr_data", data1, e_data[1]);
    chk("fifo_cnt", {cnt1, cnt0}, {2{3'(mq_addr.size())}});
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  logic [4:0] ra, rb;
  int pa, pb;

  initial begin
    rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_addr = '0; a_data = '0; b_addr = '0; b_data = '0;
    for (int k = 0; k < 2; k++) begin
      e_en[k] = 1'b0; e_addr[k] = '0; e_data[k] = '0;
    end

    // Reset state
    cycle(1'b1, 1'b1, 5'd7, 32'h1, 1'b1, 5'd8, 32'h2);
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    chk("rst_cnt", cnt0, 3'd0);
    chk("rst_en", en0, 1'b0);

    // A-only write appears one cycle after acceptance, then drops
    cycle(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
    chk("a_only_addr", addr0, 5'd3);
    chk("a_only_data", data0, 32'hDEADBEEF);
    idle();
    chk("a_only_en_off", en0, 1'b0);

    // B burst of four, writes in push order starting two cycles after first push
    for (int i = 1; i <= 4; i++)
      cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'(i), 32'h100 + 32'(i));
    for (int i = 0; i < 3; i++) idle();

    // Contention: A always valid, B fills the FIFO and then forces a pop
    for (int i = 1; i <= 7; i++)
      cycle(1'b0, 1'b1, 5'(10 + i), 32'hA00 + 32'(i), (i <= 4), 5'(i), 32'hB00 + 32'(i));
    for (int i = 0; i < 6; i++) idle();

    // Zero register from A: consumed in drop mode, written in keep mode
    cycle(1'b0, 1'b1, 5'd0, 32'h5A5A5A5A, 1'b0, 5'd0, 32'd0);
    chk("zero_drop_en", en0, 1'b0);
    chk("zero_keep_en", en1, 1'b1);
    chk("zero_keep_addr", addr1, 5'd0);

    // Reset with three buffered entries discards them
    for (int i = 1; i <= 3; i++)
      cycle(1'b0, 1'b1, 5'd20, 32'hC0 + 32'(i), 1'b1, 5'(i + 4), 32'hD0 + 32'(i));
    cycle(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    cycle(1'b0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'hE9);
    idle();
    chk("post_rst_b_en", en0, 1'b1);
    chk("post_rst_b_addr", addr0, 5'd9);
    idle();

    // Randomized traffic in phases of varying pressure
    for (int ph = 0; ph < 40; ph++) begin
      pa = $urandom_range(0, 100);
      pb = $urandom_range(0, 100);
      for (int i = 0; i < 60; i++) begin
        ra = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        rb = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        cycle($urandom_range(0, 99) < 2,
              $urandom_range(0, 99) < pa, ra, $urandom,
              $urandom_range(0, 99) < pb, rb, $urandom);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
